// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, status-flag bit positions and
// register-address width.
package cpu_pkg;

  localparam int unsigned RegAddrW = 4;
  localparam int unsigned AluCtrlW = 3;
  localparam int unsigned NumFlags = 5;

  // Status register layout {C,Z,V,N,GT}
  localparam int unsigned FlagC  = 4;
  localparam int unsigned FlagZ  = 3;
  localparam int unsigned FlagV  = 2;
  localparam int unsigned FlagN  = 1;
  localparam int unsigned FlagGt = 0;

  typedef enum logic [AluCtrlW-1:0] {
    AluAdd = 3'b000,
    AluXor = 3'b001,
    AluSub = 3'b010,
    AluSlt = 3'b011,
    AluSll = 3'b100,
    AluSrl = 3'b101,
    AluMul = 3'b110
  } alu_op_e;

  // Only arithmetic ops produce meaningful flags; logic/shift ops leave them alone.
  function automatic logic alu_sets_flags(logic [AluCtrlW-1:0] op);
    logic res;
    res = 1'b0;
    case (op)
      AluAdd, AluSub, AluMul: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/status_flags_reg.sv
// Status flag register {C,Z,V,N,GT} plus sticky overflow bit.
module status_flags_reg
  import cpu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                upd_i,
  input  logic                carry_i,
  input  logic                zero_i,
  input  logic                overflow_i,
  input  logic                negative_i,
  input  logic                gt_i,
  input  logic                ovf_clr_i,
  output logic [NumFlags-1:0] flags_o,
  output logic                ovf_sticky_o
);

  logic [NumFlags-1:0] flags_d, flags_q;
  logic                ovf_d, ovf_q;

  // Next-state: capture ALU flags on update; sticky set beats clear.
  always_comb begin
    flags_d = flags_q;
    ovf_d   = ovf_q;
    if (upd_i) begin
      flags_d[FlagC]  = carry_i;
      flags_d[FlagZ]  = zero_i;
      flags_d[FlagV]  = overflow_i;
      flags_d[FlagN]  = negative_i;
      flags_d[FlagGt] = gt_i;
    end
    if (upd_i && overflow_i) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // State register: reset wins, stall freezes everything including the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= '0;
      ovf_q   <= 1'b0;
    end else if (!stall_i) begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
    end
  end

  assign flags_o      = flags_q;
  assign ovf_sticky_o = ovf_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with status flags and sticky overflow.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned N  = 24,
  parameter int unsigned RW = RegAddrW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [N-1:0]        ex_result,
  input  logic                ex_carry,
  input  logic                ex_zero,
  input  logic                ex_gt,
  input  logic                ex_overflow,
  input  logic                ex_negative,
  input  logic [AluCtrlW-1:0] ex_alu_ctrl,
  input  logic                ex_flag_we,
  input  logic [RW-1:0]       ex_rd,
  input  logic [N-1:0]        ex_store_data,
  input  logic                ex_reg_we,
  input  logic                ex_mem_we,
  input  logic                ex_mem_re,
  output logic                mem_valid,
  output logic [N-1:0]        mem_result,
  output logic [N-1:0]        mem_store_data,
  output logic [RW-1:0]       mem_rd,
  output logic                mem_reg_we,
  output logic                mem_mem_we,
  output logic                mem_mem_re,
  output logic [NumFlags-1:0] flags,
  output logic                ovf_sticky,
  input  logic                ovf_clr
);

  logic          valid_d, valid_q;
  logic [N-1:0]  result_d, result_q;
  logic [N-1:0]  store_d, store_q;
  logic [RW-1:0] rd_d, rd_q;
  logic          reg_we_d, reg_we_q;
  logic          mem_we_d, mem_we_q;
  logic          mem_re_d, mem_re_q;
  logic          flag_upd;

  // A real load needs a live slot and a valid arithmetic entry that asks for flags.
  assign flag_upd = !stall && !flush && ex_valid && ex_flag_we && alu_sets_flags(ex_alu_ctrl);

  // Next-state: hold on stall, bubble on flush or invalid entry, else copy.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    rd_d     = rd_q;
    reg_we_d = reg_we_q;
    mem_we_d = mem_we_q;
    mem_re_d = mem_re_q;
    if (!stall) begin
      if (flush || !ex_valid) begin
        valid_d  = 1'b0;
        result_d = '0;
        store_d  = '0;
        rd_d     = '0;
        reg_we_d = 1'b0;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
      end else begin
        valid_d  = 1'b1;
        result_d = ex_result;
        store_d  = ex_store_data;
        rd_d     = ex_rd;
        reg_we_d = ex_reg_we;
        mem_we_d = ex_mem_we;
        mem_re_d = ex_mem_re;
      end
    end
  end

  // Pipeline register with synchronous reset; in-flight entry is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      reg_we_q <= reg_we_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
    end
  end

  status_flags_reg u_status_flags_reg (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .upd_i        (flag_upd),
    .carry_i      (ex_carry),
    .zero_i       (ex_zero),
    .overflow_i   (ex_overflow),
    .negative_i   (ex_negative),
    .gt_i         (ex_gt),
    .ovf_clr_i    (ovf_clr),
    .flags_o      (flags),
    .ovf_sticky_o (ovf_sticky)
  );

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_store_data = store_q;
  assign mem_rd         = rd_q;
  assign mem_reg_we     = reg_we_q;
  assign mem_mem_we     = mem_we_q;
  assign mem_mem_re     = mem_re_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed scenarios plus random traffic.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ovf_clr;
  logic        ex_valid, ex_carry, ex_zero, ex_gt, ex_overflow, ex_negative;
  logic [23:0] ex_result, ex_store_data;
  logic [2:0]  ex_alu_ctrl;
  logic        ex_flag_we, ex_reg_we, ex_mem_we, ex_mem_re;
  logic [3:0]  ex_rd;
  logic        mem_valid, mem_reg_we, mem_mem_we, mem_mem_re, ovf_sticky;
  logic [23:0] mem_result, mem_store_data;
  logic [3:0]  mem_rd;
  logic [4:0]  flags;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_result      (ex_result),
    .ex_carry       (ex_carry),
    .ex_zero        (ex_zero),
    .ex_gt          (ex_gt),
    .ex_overflow    (ex_overflow),
    .ex_negative    (ex_negative),
    .ex_alu_ctrl    (ex_alu_ctrl),
    .ex_flag_we     (ex_flag_we),
    .ex_rd          (ex_rd),
    .ex_store_data  (ex_store_data),
    .ex_reg_we      (ex_reg_we),
    .ex_mem_we      (ex_mem_we),
    .ex_mem_re      (ex_mem_re),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_we     (mem_reg_we),
    .mem_mem_we     (mem_mem_we),
    .mem_mem_re     (mem_mem_re),
    .flags          (flags),
    .ovf_sticky     (ovf_sticky),
    .ovf_clr        (ovf_clr)
  );

  typedef struct packed {
    logic        rst, stall, flush, ovf_clr, valid;
    logic [23:0] result;
    logic        c, z, gt, v, n;
    logic [2:0]  alu;
    logic        flag_we;
    logic [3:0]  rd;
    logic [23:0] sd;
    logic        reg_we, mem_we, mem_re;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [23:0] result;
    logic [23:0] sd;
    logic [3:0]  rd;
    logic        reg_we, mem_we, mem_re;
    logic [4:0]  flags;
    logic        ovf;
  } out_t;

  out_t act;
  assign act = {mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_we, mem_mem_we,
                mem_mem_re, flags, ovf_sticky};

  out_t  exp_q[$];
  out_t  m;
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    end
  endtask

  // Reference behaviour: priority rst > stall > flush > load.
  function automatic out_t model(input out_t cur, input stim_t s);
    out_t nx;
    logic upd;
    nx = cur;
    if (s.rst) return '0;
    if (s.stall) return cur;
    if (s.flush || !s.valid) begin
      nx.valid = 0; nx.result = 0; nx.sd = 0; nx.rd = 0;
      nx.reg_we = 0; nx.mem_we = 0; nx.mem_re = 0;
    end else begin
      nx.valid = 1; nx.result = s.result; nx.sd = s.sd; nx.rd = s.rd;
      nx.reg_we = s.reg_we; nx.mem_we = s.mem_we; nx.mem_re = s.mem_re;
    end
    upd = !s.flush && s.valid && s.flag_we &&
          (s.alu == 3'd0 || s.alu == 3'd2 || s.alu == 3'd6);
    if (upd) nx.flags = {s.c, s.z, s.v, s.n, s.gt};
    if (upd && s.v) nx.ovf = 1'b1;
    else if (s.ovf_clr) nx.ovf = 1'b0;
    return nx;
  endfunction

  // Drive one cycle of stimulus, queue the expected post-edge state.
  task automatic step(input stim_t s);
    rst = s.rst; stall = s.stall; flush = s.flush; ovf_clr = s.ovf_clr;
    ex_valid = s.valid; ex_result = s.result;
    ex_carry = s.c; ex_zero = s.z; ex_gt = s.gt; ex_overflow = s.v; ex_negative = s.n;
    ex_alu_ctrl = s.alu; ex_flag_we = s.flag_we; ex_rd = s.rd; ex_store_data = s.sd;
    ex_reg_we = s.reg_we; ex_mem_we = s.mem_we; ex_mem_re = s.mem_re;
    m = model(m, s);
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst     = ($urandom_range(0, 39) == 0);
    s.stall   = ($urandom_range(0, 4) == 0);
    s.flush   = ($urandom_range(0, 7) == 0);
    s.ovf_clr = ($urandom_range(0, 5) == 0);
    s.valid   = ($urandom_range(0, 3) != 0);
    s.result  = 24'($urandom());
    s.c = 1'($urandom()); s.z = 1'($urandom()); s.gt = 1'($urandom());
    s.v = 1'($urandom()); s.n = 1'($urandom());
    s.alu     = 3'($urandom_range(0, 7));
    s.flag_we = 1'($urandom());
    s.rd      = 4'($urandom());
    s.sd      = 24'($urandom());
    s.reg_we = 1'($urandom()); s.mem_we = 1'($urandom()); s.mem_re = 1'($urandom());
    return s;
  endfunction

  // Monitor: one expected entry per clock edge, checked 1 time unit after it.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", 64'(act), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s, idle;
    idle = '0;

    // Reset
    s = idle; s.rst = 1;
    step(s);
    step(s);
    chk("reset_all_zero", 64'(act), 64'd0);

    // Basic load
    s = idle; s.valid = 1; s.result = 24'h001234; s.rd = 4'd5; s.reg_we = 1;
    step(s);
    chk("load_valid", 64'(mem_valid), 64'd1);
    chk("load_result", 64'(mem_result), 64'h001234);
    chk("load_rd", 64'(mem_rd), 64'd5);
    chk("load_reg_we", 64'(mem_reg_we), 64'd1);

    // SUB updates flags, XOR leaves them
    s = idle; s.valid = 1; s.alu = 3'b010; s.z = 1; s.flag_we = 1;
    step(s);
    chk("sub_flags", 64'(flags), 64'b01000);
    s = idle; s.valid = 1; s.alu = 3'b001; s.flag_we = 1; s.c = 1; s.n = 1;
    step(s);
    chk("xor_flags_hold", 64'(flags), 64'b01000);

    // Stall dominates flush for three cycles of changing input
    s = idle; s.valid = 1; s.result = 24'hABCDEF; s.rd = 4'd9; s.reg_we = 1;
    step(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.rst = 0; s.stall = 1; s.flush = 1;
      s.valid = 1; s.flag_we = 1; s.alu = 3'b000;
      step(s);
      chk("stall_result", 64'(mem_result), 64'hABCDEF);
      chk("stall_flags", 64'(flags), 64'b01000);
    end
    s = idle; s.flush = 1; s.valid = 1; s.result = 24'h111111; s.reg_we = 1;
    step(s);
    chk("flush_valid", 64'(mem_valid), 64'd0);
    chk("flush_result", 64'(mem_result), 64'd0);
    chk("flush_reg_we", 64'(mem_reg_we), 64'd0);

    // Sticky overflow: set, set beats clear, clear alone
    s = idle; s.valid = 1; s.alu = 3'b000; s.flag_we = 1; s.v = 1;
    step(s);
    chk("ovf_set", 64'(ovf_sticky), 64'd1);
    s.ovf_clr = 1;
    step(s);
    chk("ovf_set_wins", 64'(ovf_sticky), 64'd1);
    s = idle; s.ovf_clr = 1;
    step(s);
    chk("ovf_clr", 64'(ovf_sticky), 64'd0);
    chk("flags_after_add_ovf", 64'(flags), 64'b00100);

    // Invalid entry is a bubble and touches no flags
    s = idle; s.valid = 0; s.mem_we = 1; s.flag_we = 1; s.alu = 3'b000; s.c = 1; s.z = 1;
    step(s);
    chk("inv_mem_we", 64'(mem_mem_we), 64'd0);
    chk("inv_valid", 64'(mem_valid), 64'd0);
    chk("inv_flags", 64'(flags), 64'b00100);

    // Reset beats stall and a valid load
    s = idle; s.valid = 1; s.result = 24'h00BEEF; s.alu = 3'b110; s.flag_we = 1;
    s.c = 1; s.v = 1; s.mem_re = 1;
    step(s);
    s.rst = 1; s.stall = 1;
    step(s);
    chk("rst_over_stall", 64'(act), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(rand_stim());
    end
    step(idle);

    @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
